// File: rtl/fpu_add_normalize_if.sv
// Operand/result bundle with valid/ready handshakes on both sides of the FP adder
// normalize-and-round stage. The master drives operands; the slave is the stage itself.
interface fpu_add_normalize_if #(
  parameter int unsigned FORMAT_LENGTH             = 32,
  parameter int unsigned EXPONENT_LENGTH           = 8,
  parameter int unsigned NORMALIZE_MANTISSA_LENGTH = 24
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_sum;
  logic                                 cout;
  logic                                 sign_in;
  logic [EXPONENT_LENGTH-1:0]           exp_in;
  logic [2:0]                           grs_in;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [FORMAT_LENGTH-1:0]             result;
  logic                                 overflow;
  logic                                 underflow;

  modport master (
    output in_valid, man_sum, cout, sign_in, exp_in, grs_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, man_sum, cout, sign_in, exp_in, grs_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fpu_add_normalize.sv
// Post-add normalize and round-to-nearest-even stage of the single-precision adder.
// Define FPU_NORM_FAST_EN to normalize in one cycle (LZC + barrel shift) instead of bit-serially.
module fpu_add_normalize #(
  parameter int unsigned FORMAT_LENGTH             = 32,
  parameter int unsigned EXPONENT_LENGTH           = 8,
  parameter int unsigned NORMALIZE_MANTISSA_LENGTH = 24
) (
  input logic                clk,
  input logic                rst,
  fpu_add_normalize_if.slave bus
);
  localparam int unsigned MW    = NORMALIZE_MANTISSA_LENGTH;
  localparam int unsigned ExpW  = EXPONENT_LENGTH;
  localparam int unsigned FracW = MW - 1;
  localparam logic [ExpW:0] ExpOne = {{ExpW{1'b0}}, 1'b1};
  localparam logic [ExpW:0] ExpInf = {1'b0, {ExpW{1'b1}}};

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e                   state_q, state_d;
  logic [MW-1:0]            man_q, man_d;
  logic                     g_q, g_d, r_q, r_d, s_q, s_d, sign_q, sign_d;
  logic [ExpW:0]            exp_q, exp_d;
  logic [FORMAT_LENGTH-1:0] result_q, result_d;
  logic                     ovf_q, ovf_d, unf_q, unf_d, out_valid_q, out_valid_d;

  logic [ExpW:0] exp_inc_in, exp_rnd;
  logic [MW:0]   man_rnd;
  logic [MW-1:0] man_fin;
  logic          round_up;

`ifdef FPU_NORM_FAST_EN
  logic [ExpW:0]   lz, shamt;
  logic [2*MW-1:0] ext;

  function automatic logic [ExpW:0] lzc(input logic [MW-1:0] m);
    logic [ExpW:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && !m[i]) n = n + ExpOne;
      else found = 1'b1;
    end
    return n;
  endfunction
`endif

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

  always_comb begin
    state_d     = state_q;
    man_d       = man_q;
    g_d         = g_q;
    r_d         = r_q;
    s_d         = s_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = out_valid_q;

    exp_inc_in = {1'b0, bus.exp_in} + ExpOne;
    round_up   = g_q & (r_q | s_q | man_q[0]);
    man_rnd    = {1'b0, man_q} + {{MW{1'b0}}, round_up};
    // A carry out of the rounder leaves the mantissa at exactly 1.0 with exponent bumped.
    man_fin    = man_rnd[MW] ? {1'b1, {FracW{1'b0}}} : man_rnd[MW-1:0];
    exp_rnd    = man_rnd[MW] ? exp_q + ExpOne : exp_q;
`ifdef FPU_NORM_FAST_EN
    lz    = lzc(man_q);
    shamt = (lz < exp_q - ExpOne) ? lz : exp_q - ExpOne;
    ext   = {man_q, g_q, r_q, {(MW - 2){1'b0}}} << shamt;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d = bus.sign_in;
          if (bus.cout) begin
            man_d = {1'b1, bus.man_sum[MW-1:1]};
            g_d   = bus.man_sum[0];
            r_d   = bus.grs_in[2];
            s_d   = bus.grs_in[1] | bus.grs_in[0];
            exp_d = exp_inc_in;
            if (exp_inc_in == ExpInf) begin
              result_d    = {bus.sign_in, {ExpW{1'b1}}, {FracW{1'b0}}};
              ovf_d       = 1'b1;
              unf_d       = 1'b0;
              out_valid_d = 1'b1;
              state_d     = StDone;
            end else begin
              state_d = StNorm;
            end
          end else if (bus.man_sum == '0) begin
            // Exact cancellation always yields +0.
            result_d    = '0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            man_d   = bus.man_sum;
            g_d     = bus.grs_in[2];
            r_d     = bus.grs_in[1];
            s_d     = bus.grs_in[0];
            exp_d   = {1'b0, bus.exp_in};
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
`ifdef FPU_NORM_FAST_EN
        man_d   = ext[2*MW-1:MW];
        g_d     = ext[MW-1];
        r_d     = ext[MW-2];
        exp_d   = exp_q - shamt;
        state_d = StRound;
`else
        if (man_q[MW-1] || exp_q == ExpOne) begin
          state_d = StRound;
        end else begin
          man_d = {man_q[MW-2:0], g_q};
          g_d   = r_q;
          r_d   = 1'b0;
          exp_d = exp_q - ExpOne;
        end
`endif
      end
      StRound: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (exp_rnd == ExpInf) begin
          result_d = {sign_q, {ExpW{1'b1}}, {FracW{1'b0}}};
          ovf_d    = 1'b1;
        end else if (!man_fin[MW-1]) begin
          result_d = {sign_q, {ExpW{1'b0}}, man_fin[FracW-1:0]};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[ExpW-1:0], man_fin[FracW-1:0]};
        end
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      man_q       <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      man_q       <= man_d;
      g_q         <= g_d;
      r_q         <= r_d;
      s_q         <= s_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_fpu_add_normalize.sv
// Bench for fpu_add_normalize: directed vectors, randomized operands against an arithmetic
// reference model, backpressure, back-to-back transfers and asynchronous reset mid-operation.
module tb_fpu_add_normalize;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fpu_add_normalize_if bus ();

  fpu_add_normalize dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] ms;
    logic        co;
    logic        sg;
    logic [7:0]  ei;
    logic [2:0]  grs;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic [7:0]  lat_slow;
    logic [7:0]  lat_fast;
  } vec_t;

  // Value-level model: treat {mantissa, guard, round} as one integer, normalize by doubling
  // until the leading bit is set or the exponent floor is hit, then round to nearest even.
  function automatic void model(input logic [23:0] ms, input logic co, input logic sg,
                                input logic [7:0] ei, input logic [2:0] grs,
                                output logic [31:0] res, output logic ovf, output logic unf,
                                output int lat);
    longint full, v, mant;
    logic   st, g, r;
    int     e, k;
    logic [7:0]  ebits;
    logic [22:0] frac;
    ovf  = 1'b0;
    unf  = 1'b0;
    res  = '0;
    lat  = 1;
    e    = int'(ei);
    full = (longint'(co) << 27) + (longint'(ms) << 3) + longint'(grs);
    if (co) begin
      v  = full >> 2;
      st = grs[1] | grs[0];
      e  = e + 1;
      if (e == 255) begin
        res = {sg, 8'hFF, 23'h0};
        ovf = 1'b1;
        return;
      end
    end else if (ms == 24'h0) begin
      return;
    end else begin
      v  = full >> 1;
      st = grs[0];
    end
    k = 0;
    while (v < (longint'(1) << 25) && e > 1) begin
      v = v * 2;
      e = e - 1;
      k = k + 1;
    end
    mant = v >> 2;
    g    = ((v >> 1) & 1) != 0;
    r    = (v & 1) != 0;
    if (g && (r || st || (mant % 2) == 1)) mant = mant + 1;
    if (mant == (longint'(1) << 24)) begin
      mant = longint'(1) << 23;
      e    = e + 1;
    end
    frac  = 23'(mant);
    ebits = 8'(e);
    if (e == 255) begin
      res = {sg, 8'hFF, 23'h0};
      ovf = 1'b1;
    end else if (mant < (longint'(1) << 23)) begin
      res = {sg, 8'h00, frac};
      unf = 1'b1;
    end else begin
      res = {sg, ebits, frac};
    end
`ifdef FPU_NORM_FAST_EN
    lat = 3;
`else
    lat = 3 + k;
`endif
  endfunction

  // Presents one operand, waits for acceptance, then counts edges until out_valid.
  task automatic start_op(input logic [23:0] ms, input logic co, input logic sg,
                          input logic [7:0] ei, input logic [2:0] grs,
                          output int lat, output bit ok);
    int n;
    @(negedge clk);
    bus.man_sum  = ms;
    bus.cout     = co;
    bus.sign_in  = sg;
    bus.exp_in   = ei;
    bus.grs_in   = grs;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.in_ready === 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    ok = ok && (bus.out_valid === 1'b1);
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.man_sum   = '0;
    bus.cout      = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = '0;
    bus.grs_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.overflow !== 1'b0 ||
        bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h o=%b u=%b want 0/0/0/0", bus.out_valid,
               bus.result, bus.overflow, bus.underflow);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[10];
    int   lat, want_lat;
    bit   ok;
    tbl[0] = '{24'hFDDBDF, 1'b0, 1'b0, 8'h80, 3'b000, 32'h407DDBDF, 1'b0, 1'b0, 8'd3, 8'd3};
    tbl[1] = '{24'h82B048, 1'b1, 1'b0, 8'h80, 3'b000, 32'h40C15824, 1'b0, 1'b0, 8'd3, 8'd3};
    tbl[2] = '{24'h280000, 1'b0, 1'b0, 8'h80, 3'b000, 32'h3F200000, 1'b0, 1'b0, 8'd5, 8'd3};
    tbl[3] = '{24'hFFFFFF, 1'b0, 1'b0, 8'h80, 3'b110, 32'h40800000, 1'b0, 1'b0, 8'd3, 8'd3};
    tbl[4] = '{24'hFFFFFE, 1'b0, 1'b0, 8'h80, 3'b100, 32'h407FFFFE, 1'b0, 1'b0, 8'd3, 8'd3};
    tbl[5] = '{24'h800000, 1'b1, 1'b1, 8'hFE, 3'b000, 32'hFF800000, 1'b1, 1'b0, 8'd1, 8'd1};
    tbl[6] = '{24'h000000, 1'b0, 1'b1, 8'h80, 3'b000, 32'h00000000, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[7] = '{24'hFFFFFF, 1'b0, 1'b1, 8'hFE, 3'b110, 32'hFF800000, 1'b1, 1'b0, 8'd3, 8'd3};
    tbl[8] = '{24'h000100, 1'b0, 1'b0, 8'h03, 3'b000, 32'h00000400, 1'b0, 1'b1, 8'd5, 8'd3};
    tbl[9] = '{24'h7FFFFF, 1'b0, 1'b0, 8'h01, 3'b110, 32'h00800000, 1'b0, 1'b0, 8'd3, 8'd3};
    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].ms, tbl[i].co, tbl[i].sg, tbl[i].ei, tbl[i].grs, lat, ok);
`ifdef FPU_NORM_FAST_EN
      want_lat = int'(tbl[i].lat_fast);
`else
      want_lat = int'(tbl[i].lat_slow);
`endif
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL dir%0d handshake: timed out", i);
      end
      checks++;
      if (bus.result !== tbl[i].res) begin
        errors++;
        $display("FAIL dir%0d result: got %h want %h", i, bus.result, tbl[i].res);
      end
      checks++;
      if (bus.overflow !== tbl[i].ovf || bus.underflow !== tbl[i].unf) begin
        errors++;
        $display("FAIL dir%0d flags: got o=%b u=%b want o=%b u=%b", i, bus.overflow,
                 bus.underflow, tbl[i].ovf, tbl[i].unf);
      end
      checks++;
      if (lat != want_lat) begin
        errors++;
        $display("FAIL dir%0d latency: got %0d want %0d", i, lat, want_lat);
      end
      finish_op();
    end
  endtask

  task automatic test_random();
    logic [31:0] r32, want_res;
    logic [23:0] ms;
    logic        co, sg, want_ovf, want_unf;
    logic [7:0]  ei;
    logic [2:0]  grs;
    int          lat, want_lat;
    bit          ok;
    for (int i = 0; i < 80; i++) begin
      r32 = $urandom;
      r32 = r32 >> $urandom_range(0, 24);
      ms  = r32[23:0];
      co  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      grs = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ei = 8'($urandom_range(1, 254));
        1:       ei = 8'($urandom_range(1, 24));
        2:       ei = 8'($urandom_range(250, 254));
        default: ei = 8'($urandom_range(100, 140));
      endcase
      model(ms, co, sg, ei, grs, want_res, want_ovf, want_unf, want_lat);
      start_op(ms, co, sg, ei, grs, lat, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd%0d handshake: timed out", i);
      end
      checks++;
      if (bus.result !== want_res) begin
        errors++;
        $display("FAIL rnd%0d result: ms=%h co=%b e=%h grs=%b got %h want %h", i, ms, co, ei,
                 grs, bus.result, want_res);
      end
      checks++;
      if (bus.overflow !== want_ovf || bus.underflow !== want_unf) begin
        errors++;
        $display("FAIL rnd%0d flags: got o=%b u=%b want o=%b u=%b", i, bus.overflow,
                 bus.underflow, want_ovf, want_unf);
      end
      checks++;
      if (lat != want_lat) begin
        errors++;
        $display("FAIL rnd%0d latency: got %0d want %0d", i, lat, want_lat);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    start_op(24'hFDDBDF, 1'b0, 1'b0, 8'h80, 3'b000, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp handshake: timed out");
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'h407DDBDF) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b r=%h want 1/0/407ddbdf", c, bus.out_valid,
                 bus.in_ready, bus.result);
      end
      @(posedge clk);
      #1;
    end
    finish_op();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    start_op(24'h82B048, 1'b1, 1'b0, 8'h80, 3'b000, lat, ok);
    finish_op();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_turnaround: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    start_op(24'hFFFFFE, 1'b0, 1'b1, 8'h80, 3'b100, lat, ok);
    checks++;
    if (!ok || bus.result !== 32'hC07FFFFE || lat != 3) begin
      errors++;
      $display("FAIL b2b_second: got ok=%b r=%h lat=%0d want 1/c07ffffe/3", ok, bus.result, lat);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    @(negedge clk);
    bus.man_sum  = 24'h000001;
    bus.cout     = 1'b0;
    bus.sign_in  = 1'b0;
    bus.exp_in   = 8'h80;
    bus.grs_in   = 3'b000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: got rdy=%b want 0", bus.in_ready);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got v=%b r=%h rdy=%b want 0/0/0", bus.out_valid,
               bus.result, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_op(24'h280000, 1'b0, 1'b0, 8'h80, 3'b000, lat, ok);
    checks++;
    if (!ok || bus.result !== 32'h3F200000 || bus.overflow !== 1'b0 ||
        bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_recover: got ok=%b r=%h o=%b u=%b want 1/3f200000/0/0", ok,
               bus.result, bus.overflow, bus.underflow);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_add_normalize.md
# fpu_add_normalize

Post-addition normalize-and-round stage of the single-precision FP adder. Sits directly downstream of the 24-bit CLA mantissa add/sub stage. It consumes the raw 24-bit magnitude, carry-out, result sign, common (larger) exponent and guard/round/sticky bits from alignment, and produces a packed IEEE-754 single-precision result. It uses round-to-nearest-even and a valid/ready handshake on both sides.

## Interface
- FORMAT_LENGTH, 32, packed result width
- EXPONENT_LENGTH, 8, biased exponent width
- NORMALIZE_MANTISSA_LENGTH, 24, mantissa width including hidden bit
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream operand valid
- in_ready  output  1  stage can accept; = (state==IDLE) && !rst
- man_sum  input  24  magnitude from the add/sub stage
- cout  input  1  carry-out from the add/sub stage
- sign_in  input  1  result sign from the add/sub stage
- exp_in  input  8  common biased exponent, legal range 1..254
- grs_in  input  3  {guard, round, sticky} from alignment
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- result  output  32  packed {sign, exp[7:0], frac[22:0]}
- overflow  output  1  result rounded to infinity
- underflow  output  1  result is denormal or zero after nonzero input

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE: an input is accepted on the edge where in_valid && in_ready. The stage captures the operands as follows:
  - cout=1: mantissa = {1, man_sum[23:1]}; guard = man_sum[0]; round = G_in; sticky = R_in|S_in; exp = exp_in+1.
    - If exp = 255: go to DONE with ±infinity and overflow=1.
  - cout=0, man_sum=0: go to DONE with +0 (sign forced to 0) and underflow=0.
  - Otherwise: go to NORM.
- NORM:
  - If mantissa[23]=1 or exp=1: go to ROUND.
  - Otherwise: shift left 1, shifting in guard; guard←round; round←0; sticky held; exp−1.
- Exponent arithmetic is internally 9 bits wide, so it never wraps. Exp floor is 1.
- ROUND:
  - Round up when G && (R|S|mantissa[0]).
  - Carry out of the mantissa gives mantissa=0x800000 and exp+1.
    - If exp reaches 255: result = ±infinity, overflow=1.
  - If mantissa[23]=0 after rounding: exponent field = 0 (denormal), underflow=1.
  - Then go to DONE.
- DONE:
  - result and flags are registered; out_valid=1.
  - Values are held stable until out_ready=1. On that edge: out_valid←0, go to IDLE.
- exp_in values 0 and 255 are illegal. The stage does not check them; upstream handles specials.

## Timing
- Reset values: out_valid=0, result=0, overflow=0, underflow=0, state=IDLE.
- in_ready=0 while rst is asserted.
- Reset asserted mid-operation aborts the operation immediately; the partial result is discarded.
- Latency is counted from the accept edge to the first cycle with out_valid=1:
  - Zero or immediate overflow: 1 cycle.
  - Otherwise: 3 + k cycles, where k = number of left shifts (0..23, bounded by exp_in−1).
- Throughput: one operation in flight. in_ready stays low from accept until DONE is handshaken.
- out_valid and out_ready high on the same edge completes the transfer. The next accept can occur no earlier than the following edge.

## Configuration
- FPU_NORM_FAST_EN defined: NORM does the full shift in one cycle.
  - Shift amount = min(leading-zero count of mantissa, exp−1), via LZC plus barrel shifter.
  - Shifted-in bits are G, R, then zeros.
  - Latency is a fixed 3 cycles (1 for the zero/overflow cases).
- Undefined: one bit per cycle, as described in Operation. Results are bit-identical in both modes; only latency differs.

## Test plan
- Plain sum: man_sum=0xFDDBDF, cout=0, exp_in=0x80, sign=0, grs=0 → result=0x407DDBDF, latency 3, no flags.
- Carry-out: man_sum=0x82B048, cout=1, exp_in=0x80 → result=0x40C15824 (exp 0x81).
- Cancellation: man_sum=0x280000, cout=0, exp_in=0x80 → result=0x3F200000.
  - Latency 5 (slow) / 3 (FPU_NORM_FAST_EN).
- Rounding carry: man_sum=0xFFFFFF, grs=3'b110, exp_in=0x80 → result=0x40800000.
  - Also: grs=3'b100 with man_sum=0xFFFFFE (even) → no round-up, result=0x407FFFFE.
- Overflow/zero: exp_in=0xFE, cout=1, sign=1 → result=0xFF800000, overflow=1, latency 1.
  - Also: man_sum=0, cout=0, sign=1 → result=0x00000000.
- Backpressure/reset: hold out_ready=0 for 5 cycles → result stable and in_ready=0 throughout.
  - Assert rst during NORM → out_valid=0 and result=0 asynchronously, and a fresh input after release completes correctly.
